// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, FSM state type and shift helpers for the execute stage.
// ALU_BARREL_SHIFT_EN selects the single-cycle full-shift function over the iterative shifter.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [4:0] ALU_ADD     = 5'd0;
  localparam logic [4:0] ALU_SUB     = 5'd1;
  localparam logic [4:0] ALU_SLT     = 5'd2;
  localparam logic [4:0] ALU_SLTU    = 5'd3;
  localparam logic [4:0] ALU_XOR     = 5'd4;
  localparam logic [4:0] ALU_OR      = 5'd5;
  localparam logic [4:0] ALU_AND     = 5'd6;
  localparam logic [4:0] ALU_LUI     = 5'd7;
  localparam logic [4:0] ALU_UNKNOWN = 5'd8;
  localparam logic [4:0] ALU_SLL     = 5'd9;
  localparam logic [4:0] ALU_SRL     = 5'd10;
  localparam logic [4:0] ALU_SRA     = 5'd11;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd2
  } alu_state_e;

  function automatic logic [XLEN-1:0] alu_full_shift(input logic [XLEN-1:0] v,
                                                     input logic [SHAMT_W-1:0] sh,
                                                     input logic [4:0] op);
    logic [XLEN-1:0] r;
    case (op)
      ALU_SLL: r = v << sh;
      ALU_SRL: r = v >> sh;
      ALU_SRA: r = $signed(v) >>> sh;
      default: r = v;
    endcase
    return r;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } alu_state_e;
`endif

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift step: SLL/SRL fill zero, SRA replicates bit XLEN-1.
// Zero latency, no flow control; any non-shift op passes the value through.
module alu_shift_step
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] value_in,
  input  logic [4:0]      op,
  output logic [XLEN-1:0] value_out
);

  always_comb begin
    value_out = value_in;
    case (op)
      ALU_SLL: value_out = {value_in[XLEN-2:0], 1'b0};
      ALU_SRL: value_out = {1'b0, value_in[XLEN-1:1]};
      ALU_SRA: value_out = {value_in[XLEN-1], value_in[XLEN-1:1]};
      default: value_out = value_in;
    endcase
  end

endmodule

// File: rtl/execute_alu_core.sv
// Execute-stage ALU back end: 1-cycle arithmetic/logic, shamt-cycle iterative shifts (1 cycle
// with ALU_BARREL_SHIFT_EN); result held in HOLD until out_ready, in_ready only in IDLE.
module execute_alu_core
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN:0]   in_a,
  input  logic [XLEN:0]   in_b,
  input  logic [4:0]      alu_op,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal,
  output logic            out_valid,
  input  logic            out_ready
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            valid_q, valid_d;

  logic [XLEN:0]   diff;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  assign in_ready    = (state_q == ST_IDLE);
  assign out_result  = result_q;
  assign out_illegal = illegal_q;
  assign out_valid   = valid_q;

  always_comb begin
    diff    = in_a - in_b;
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op)
      ALU_ADD:  alu_res = in_a[XLEN-1:0] + in_b[XLEN-1:0];
      ALU_SUB:  alu_res = diff[XLEN-1:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_a[XLEN-1:0]) < $signed(in_b[XLEN-1:0])};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, diff[XLEN]};
      ALU_XOR:  alu_res = in_a[XLEN-1:0] ^ in_b[XLEN-1:0];
      ALU_OR:   alu_res = in_a[XLEN-1:0] | in_b[XLEN-1:0];
      ALU_AND:  alu_res = in_a[XLEN-1:0] & in_b[XLEN-1:0];
      ALU_LUI:  alu_res = in_b[XLEN-1:0];
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA:
        alu_res = alu_full_shift(in_a[XLEN-1:0], in_b[SHAMT_W-1:0], alu_op);
`else
      // Only reached for shamt==0; non-zero shifts go through the step datapath.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = in_a[XLEN-1:0];
`endif
      default:  alu_ill = 1'b1;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic [XLEN-1:0]    step_in, step_out;
  logic [4:0]         step_op;
  logic [SHAMT_W-1:0] shamt;

  // The first bit is shifted on the accept edge so total latency equals shamt.
  assign step_in = (state_q == ST_IDLE) ? in_a[XLEN-1:0] : work_q;
  assign step_op = (state_q == ST_IDLE) ? alu_op : op_q;
  assign shamt   = in_b[SHAMT_W-1:0];

  alu_shift_step u_shift_step (
    .value_in  (step_in),
    .op        (step_op),
    .value_out (step_out)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
`ifndef ALU_BARREL_SHIFT_EN
    work_d    = work_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift_op(alu_op) && (shamt > 1)) begin
            op_d    = alu_op;
            work_d  = step_out;
            cnt_d   = shamt - 1'b1;
            state_d = ST_SHIFT;
          end else if (is_shift_op(alu_op) && (shamt == 1)) begin
            result_d  = step_out;
            illegal_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
          end else
`endif
          begin
            result_d  = alu_res;
            illegal_d = alu_ill;
            valid_d   = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      ST_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          result_d  = step_out;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      work_q    <= '0;
      cnt_q     <= '0;
      op_q      <= ALU_ADD;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
`ifndef ALU_BARREL_SHIFT_EN
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
`endif
    end
  end

endmodule
